micro32_pipe: RTL and testbench
===============================

Name: micro32_pipe

Overview:
Five-stage (IF, ID, EX, MEM, WB) pipelined 32-bit RISC core.
- Internal 32x32 register file and a unified word-addressed instruction/data memory.
- Programs and initial register values are preloaded by the bench through the internal arrays `Reg` and `Mem`.
- Execution runs from address 0 after reset and stops at HLT.
- Standalone execution core, used as a teaching/verification vehicle.

Parameters:
MEM_DEPTH, 1024, number of 32-bit words in unified memory (address = low log2(MEM_DEPTH) bits)

Ports:
clk  input  1  single system clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
halted  output  1  high once HLT has retired; sticky until reset
pc  output  32  current fetch address (word index)

Behaviour:
- Storage:
  - Internal arrays `Reg[0:31]` (32b) and `Mem[0:MEM_DEPTH-1]` (32b) are hierarchically accessible.
  - Neither is cleared by reset.
  - R0 always reads 0; writes to R0 are discarded.
- Reset (synchronous): pc=0, halted=0, all pipeline registers invalid/NOP, branch flush state cleared.
  - Reset mid-program aborts all in-flight instructions (no further Reg/Mem writes); Reg and Mem contents are kept.
- Instruction format: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0] (sign-extended to 32b).
- RR opcodes (rd <= rs op rt):
  - ADD 000000, SUB 000001, AND 000010, OR 000011.
  - SLT 000100: signed compare, result 1/0.
  - MUL 000101: low 32 bits of product.
- RM opcodes (rt <= rs op imm): ADDI 001010, SUBI 001011, SLTI 001100 (signed).
- Memory:
  - LW 001000: rt <= Mem[rs+imm].
  - SW 001001: Mem[rs+imm] <= rt.
  - Address uses the low address bits only.
- Branches: BNEQZ 001101 (taken if rs!=0), BEQZ 001110 (taken if rs==0); target = branch_pc + 1 + imm.
- HLT 111111. Any other opcode executes as a NOP (no writes).
- Arithmetic wraps modulo 2^32; no flags or exceptions.
- Timing: one instruction per cycle when unstalled. Instruction fetched in cycle n has ID n+1, EX n+2, MEM n+3, WB n+4.
  - Register file written in WB.
  - ID read of a register being written by WB in the same cycle returns the new value (write-through).
- Forwarding into EX:
  - EX/MEM ALU result takes priority over MEM/WB result (ALU or load data); matched on destination register != 0.
  - Load-use at distance 1 is NOT interlocked: the consumer receives the stale value, and software must insert one independent instruction. Distance >= 2 is correct.
- Branch resolution in EX using the forwarded rs:
  - If taken: pc <= target next cycle and the two younger instructions (in IF/ID and ID/EX) become NOPs.
  - No delay slots, no prediction (fall-through fetch).
- Halt:
  - When HLT is in ID, fetch stops: pc frozen and NOPs are injected.
  - Older instructions drain and complete normally.
  - halted rises the cycle after HLT reaches WB; the core then stays idle until rst.
  - A taken branch older than HLT cancels the HLT and fetch resumes at the target.
- SW writes Mem in its MEM stage; a LW in the immediately following instruction at the same address sees the stored value.

Test Plan:
- Preload Reg[k]=k and Mem[0..8] = 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000; pulse rst -> halted within 20 cycles; R0..R5 = 0, 10, 20, 25, 30, 55.
- Back-to-back dependency: ADDI R1,R0,5; ADD R2,R1,R1; ADD R3,R2,R1; HLT -> R2=10, R3=15 (forwarding).
- Memory: ADDI R1,R0,100; ADDI R2,R0,-7; SW R2,0(R1); LW R3,0(R1); OR R7,R7,R7; ADD R4,R3,R3; HLT -> Mem[100]=FFFFFFF9, R4=FFFFFFF2.
- Loop: R1=3, R2=0; loop body SUBI R1,R1,1; ADDI R2,R2,2; BNEQZ R1,-3; HLT -> R1=0, R2=6; the two instructions fetched after each taken branch have no effect.
- Signed and edge ops: SLT on FFFFFFFF vs 1 gives 1; MUL 0x10000 x 0x10000 gives 0; ADDI to R0 leaves R0=0.
- Assert rst in the middle of the loop -> pc=0, halted=0, no further writes in that cycle; Reg values retained; program re-runs from 0.

Source files
------------

// File: rtl/micro32_pipe.sv
// Five-stage pipelined 32-bit RISC core with unified word-addressed memory,
// full EX forwarding (except load-use at distance 1) and branch resolution in EX.
module micro32_pipe #(
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic        halted,
  output logic [31:0] pc
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef struct packed {
    logic        v;
    logic [31:0] ir;
    logic [31:0] pc;
  } ifid_t;

  typedef struct packed {
    logic        v;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic        we;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] pc;
  } idex_t;

  typedef struct packed {
    logic        v;
    logic [5:0]  op;
    logic [4:0]  dest;
    logic        we;
    logic [31:0] alu;
    logic [31:0] sdata;
  } exmem_t;

  typedef struct packed {
    logic        v;
    logic [4:0]  dest;
    logic        we;
    logic [31:0] val;
    logic        hlt;
  } memwb_t;

  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:MEM_DEPTH-1];

  logic [31:0] r_pc;
  logic        r_halted;
  logic        r_stop;
  ifid_t       r_ifid;
  idex_t       r_idex;
  exmem_t      r_exmem;
  memwb_t      r_memwb;

  logic [31:0] w_fetch;
  logic [5:0]  w_id_op;
  logic [4:0]  w_id_rs, w_id_rt, w_id_rd;
  logic [31:0] w_id_imm;
  logic        w_id_hlt;
  logic        w_wb_we;
  idex_t       w_idex_nxt;
  logic [31:0] w_ex_a, w_ex_b, w_ex_alu, w_ex_target;
  logic        w_ex_taken;
  logic [31:0] w_mem_val;

  assign halted  = r_halted;
  assign pc      = r_pc;
  assign w_fetch = Mem[r_pc[AW-1:0]];

  // ID: decode and register read with write-through from WB
  assign w_id_op  = r_ifid.ir[31:26];
  assign w_id_rs  = r_ifid.ir[25:21];
  assign w_id_rt  = r_ifid.ir[20:16];
  assign w_id_rd  = r_ifid.ir[15:11];
  assign w_id_imm = {{16{r_ifid.ir[15]}}, r_ifid.ir[15:0]};
  assign w_id_hlt = r_ifid.v && (w_id_op == OP_HLT);
  assign w_wb_we  = r_memwb.v && r_memwb.we;

  always_comb begin
    w_idex_nxt      = '0;
    w_idex_nxt.v    = r_ifid.v;
    w_idex_nxt.op   = w_id_op;
    w_idex_nxt.rs   = w_id_rs;
    w_idex_nxt.rt   = w_id_rt;
    w_idex_nxt.imm  = w_id_imm;
    w_idex_nxt.pc   = r_ifid.pc;
    case (w_id_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: w_idex_nxt.dest = w_id_rd;
      OP_ADDI, OP_SUBI, OP_SLTI, OP_LW:              w_idex_nxt.dest = w_id_rt;
      default:                                       w_idex_nxt.dest = 5'd0;
    endcase
    w_idex_nxt.we = r_ifid.v && (w_idex_nxt.dest != 5'd0);
    if (w_id_rs == 5'd0)                             w_idex_nxt.a = 32'd0;
    else if (w_wb_we && r_memwb.dest == w_id_rs)     w_idex_nxt.a = r_memwb.val;
    else                                             w_idex_nxt.a = Reg[w_id_rs];
    if (w_id_rt == 5'd0)                             w_idex_nxt.b = 32'd0;
    else if (w_wb_we && r_memwb.dest == w_id_rt)     w_idex_nxt.b = r_memwb.val;
    else                                             w_idex_nxt.b = Reg[w_id_rt];
  end

  // EX: forwarding (EX/MEM over MEM/WB; loads in EX/MEM have no data yet), ALU, branch
  always_comb begin
    w_ex_a = r_idex.a;
    w_ex_b = r_idex.b;
    if (w_wb_we && r_memwb.dest == r_idex.rs) w_ex_a = r_memwb.val;
    if (w_wb_we && r_memwb.dest == r_idex.rt) w_ex_b = r_memwb.val;
    if (r_exmem.v && r_exmem.we && r_exmem.op != OP_LW) begin
      if (r_exmem.dest == r_idex.rs) w_ex_a = r_exmem.alu;
      if (r_exmem.dest == r_idex.rt) w_ex_b = r_exmem.alu;
    end
    case (r_idex.op)
      OP_ADD:        w_ex_alu = w_ex_a + w_ex_b;
      OP_SUB:        w_ex_alu = w_ex_a - w_ex_b;
      OP_AND:        w_ex_alu = w_ex_a & w_ex_b;
      OP_OR:         w_ex_alu = w_ex_a | w_ex_b;
      OP_SLT:        w_ex_alu = {31'd0, $signed(w_ex_a) < $signed(w_ex_b)};
      OP_MUL:        w_ex_alu = w_ex_a * w_ex_b;
      OP_ADDI:       w_ex_alu = w_ex_a + r_idex.imm;
      OP_SUBI:       w_ex_alu = w_ex_a - r_idex.imm;
      OP_SLTI:       w_ex_alu = {31'd0, $signed(w_ex_a) < $signed(r_idex.imm)};
      OP_LW, OP_SW:  w_ex_alu = w_ex_a + r_idex.imm;
      default:       w_ex_alu = 32'd0;
    endcase
    w_ex_taken  = r_idex.v && (((r_idex.op == OP_BNEQZ) && (w_ex_a != 32'd0)) ||
                               ((r_idex.op == OP_BEQZ)  && (w_ex_a == 32'd0)));
    w_ex_target = r_idex.pc + 32'd1 + r_idex.imm;
  end

  assign w_mem_val = (r_exmem.op == OP_LW) ? Mem[r_exmem.alu[AW-1:0]] : r_exmem.alu;

  // Pipeline registers, fetch control and sticky halt
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= 32'd0;
      r_halted <= 1'b0;
      r_stop   <= 1'b0;
      r_ifid   <= '0;
      r_idex   <= '0;
      r_exmem  <= '0;
      r_memwb  <= '0;
    end else begin
      r_halted      <= r_halted | (r_memwb.v & r_memwb.hlt);
      r_memwb.v     <= r_exmem.v;
      r_memwb.dest  <= r_exmem.dest;
      r_memwb.we    <= r_exmem.v & r_exmem.we;
      r_memwb.val   <= w_mem_val;
      r_memwb.hlt   <= r_exmem.v & (r_exmem.op == OP_HLT);
      r_exmem.v     <= r_idex.v;
      r_exmem.op    <= r_idex.op;
      r_exmem.dest  <= r_idex.dest;
      r_exmem.we    <= r_idex.v & r_idex.we;
      r_exmem.alu   <= w_ex_alu;
      r_exmem.sdata <= w_ex_b;
      if (w_ex_taken) begin
        r_pc   <= w_ex_target;
        r_ifid <= '0;
        r_idex <= '0;
      end else if (w_id_hlt || r_stop) begin
        r_stop <= 1'b1;
        r_ifid <= '0;
        r_idex <= w_idex_nxt;
      end else begin
        r_pc      <= r_pc + 32'd1;
        r_ifid.v  <= 1'b1;
        r_ifid.ir <= w_fetch;
        r_ifid.pc <= r_pc;
        r_idex    <= w_idex_nxt;
      end
    end
  end

  // Architectural state survives reset; writes in the reset cycle are dropped
  always_ff @(posedge clk) begin
    if (!rst && w_wb_we && r_memwb.dest != 5'd0) Reg[r_memwb.dest] <= r_memwb.val;
    if (!rst && r_exmem.v && r_exmem.op == OP_SW) Mem[r_exmem.alu[AW-1:0]] <= r_exmem.sdata;
  end

endmodule

// File: tb/tb_micro32_pipe.sv
// Directed program tests for micro32_pipe with hand-computed register/memory results.
module tb_micro32_pipe;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b000010, OR_ = 6'b000011;
  localparam logic [5:0] SLT = 6'b000100, MUL = 6'b000101, LW = 6'b001000, SW = 6'b001001;
  localparam logic [5:0] ADDI = 6'b001010, SUBI = 6'b001011, SLTI = 6'b001100;
  localparam logic [5:0] BNEQZ = 6'b001101, BEQZ = 6'b001110;
  localparam logic [31:0] HLT_W = 32'hfc000000;

  logic        clk;
  logic        rst;
  logic        halted;
  logic [31:0] pc;
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc;

  micro32_pipe #(.MEM_DEPTH(1024)) dut (
    .clk    (clk),
    .rst    (rst),
    .halted (halted),
    .pc     (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rt,
                                     input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic reset_on();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
  endtask

  task automatic preload();
    for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'd0;
    for (int k = 0; k < 32; k++) dut.Reg[k] = 32'(k);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_halt(input int budget, output int n);
    n = 0;
    while (!halted && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;

    // Reference program with preloaded Reg[k]=k
    reset_on();
    preload();
    dut.Mem[0] = 32'h2801000a; dut.Mem[1] = 32'h28020014; dut.Mem[2] = 32'h28030019;
    dut.Mem[3] = 32'h0ce77800; dut.Mem[4] = 32'h0ce77800; dut.Mem[5] = 32'h00222000;
    dut.Mem[6] = 32'h0ce77800; dut.Mem[7] = 32'h00832800; dut.Mem[8] = 32'hfc000000;
    release_rst();
    run_halt(20, cyc);
    check("t1_halt_cycle", 32'(cyc), 32'd13);
    check("t1_pc_frozen", pc, 32'd9);
    check("t1_r0", dut.Reg[0], 32'd0);
    check("t1_r1", dut.Reg[1], 32'd10);
    check("t1_r2", dut.Reg[2], 32'd20);
    check("t1_r3", dut.Reg[3], 32'd25);
    check("t1_r4", dut.Reg[4], 32'd30);
    check("t1_r5", dut.Reg[5], 32'd55);
    check("t1_r15", dut.Reg[15], 32'd7);

    // Back-to-back dependencies through EX/MEM and MEM/WB forwarding
    reset_on();
    preload();
    dut.Mem[0] = ri(ADDI, 1, 0, 16'd5);
    dut.Mem[1] = rr(ADD, 2, 1, 1);
    dut.Mem[2] = rr(ADD, 3, 2, 1);
    dut.Mem[3] = HLT_W;
    release_rst();
    run_halt(50, cyc);
    check("t2_halt_cycle", 32'(cyc), 32'd8);
    check("t2_pc_frozen", pc, 32'd4);
    check("t2_r2", dut.Reg[2], 32'd10);
    check("t2_r3", dut.Reg[3], 32'd15);

    // Store/load, store-to-load adjacency, load-use at distance 2 and stale distance 1
    reset_on();
    preload();
    dut.Mem[0] = ri(ADDI, 1, 0, 16'd100);
    dut.Mem[1] = ri(ADDI, 2, 0, 16'hfff9);
    dut.Mem[2] = ri(SW, 2, 1, 16'd0);
    dut.Mem[3] = ri(LW, 3, 1, 16'd0);
    dut.Mem[4] = rr(OR_, 7, 7, 7);
    dut.Mem[5] = rr(ADD, 4, 3, 3);
    dut.Mem[6] = ri(LW, 5, 1, 16'd0);
    dut.Mem[7] = rr(ADD, 6, 5, 5);
    dut.Mem[8] = HLT_W;
    release_rst();
    run_halt(100, cyc);
    check("t3_mem100", dut.Mem[100], 32'hfffffff9);
    check("t3_r3", dut.Reg[3], 32'hfffffff9);
    check("t3_r4", dut.Reg[4], 32'hfffffff2);
    check("t3_r5", dut.Reg[5], 32'hfffffff9);
    check("t3_r6_stale", dut.Reg[6], 32'd10);
    check("t3_r7", dut.Reg[7], 32'd7);

    // Countdown loop; HLT and the word after it are squashed on each taken branch
    reset_on();
    preload();
    dut.Mem[0] = ri(ADDI, 1, 0, 16'd3);
    dut.Mem[1] = ri(ADDI, 2, 0, 16'd0);
    dut.Mem[2] = ri(SUBI, 1, 1, 16'd1);
    dut.Mem[3] = ri(ADDI, 2, 2, 16'd2);
    dut.Mem[4] = ri(BNEQZ, 0, 1, 16'hfffd);
    dut.Mem[5] = HLT_W;
    dut.Mem[6] = ri(ADDI, 5, 5, 16'd1);
    release_rst();
    run_halt(200, cyc);
    check("t4_r1", dut.Reg[1], 32'd0);
    check("t4_r2", dut.Reg[2], 32'd6);
    check("t4_r5", dut.Reg[5], 32'd5);

    // Signed compares, wrapping multiply/subtract, R0 writes, BEQZ skip
    reset_on();
    preload();
    dut.Reg[8] = 32'hffffffff; dut.Reg[9] = 32'd1; dut.Reg[10] = 32'h00010000;
    dut.Mem[0]  = rr(SLT, 11, 8, 9);
    dut.Mem[1]  = rr(SLT, 12, 9, 8);
    dut.Mem[2]  = rr(MUL, 13, 10, 10);
    dut.Mem[3]  = ri(ADDI, 0, 0, 16'd5);
    dut.Mem[4]  = rr(ADD, 14, 0, 0);
    dut.Mem[5]  = rr(SUB, 15, 0, 9);
    dut.Mem[6]  = ri(BEQZ, 0, 0, 16'd1);
    dut.Mem[7]  = ri(ADDI, 16, 0, 16'd99);
    dut.Mem[8]  = rr(AND_, 17, 8, 10);
    dut.Mem[9]  = ri(SLTI, 18, 8, 16'd0);
    dut.Mem[10] = rr(MUL, 19, 6, 7);
    dut.Mem[11] = HLT_W;
    release_rst();
    run_halt(100, cyc);
    check("t5_slt_neg", dut.Reg[11], 32'd1);
    check("t5_slt_pos", dut.Reg[12], 32'd0);
    check("t5_mul_wrap", dut.Reg[13], 32'd0);
    check("t5_r0", dut.Reg[0], 32'd0);
    check("t5_add_r0", dut.Reg[14], 32'd0);
    check("t5_sub_wrap", dut.Reg[15], 32'hffffffff);
    check("t5_beqz_skip", dut.Reg[16], 32'd16);
    check("t5_and", dut.Reg[17], 32'h00010000);
    check("t5_slti", dut.Reg[18], 32'd1);
    check("t5_mul", dut.Reg[19], 32'd42);

    // Reset in the cycle a SUBI is in WB: its write is dropped, program re-runs
    reset_on();
    preload();
    dut.Mem[0] = ri(ADDI, 1, 0, 16'd50);
    dut.Mem[1] = ri(ADDI, 2, 0, 16'd0);
    dut.Mem[2] = ri(SUBI, 1, 1, 16'd1);
    dut.Mem[3] = ri(ADDI, 2, 2, 16'd2);
    dut.Mem[4] = ri(BNEQZ, 0, 1, 16'hfffd);
    dut.Mem[5] = HLT_W;
    release_rst();
    repeat (26) @(posedge clk);
    @(negedge clk);
    check("t6_pre_r1", dut.Reg[1], 32'd46);
    check("t6_pre_r2", dut.Reg[2], 32'd8);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_pc", pc, 32'd0);
    check("t6_rst_halted", {31'd0, halted}, 32'd0);
    check("t6_kept_r1", dut.Reg[1], 32'd46);
    check("t6_kept_r2", dut.Reg[2], 32'd8);
    @(posedge clk);
    #1;
    check("t6_idle_r1", dut.Reg[1], 32'd46);
    check("t6_idle_r2", dut.Reg[2], 32'd8);
    release_rst();
    run_halt(1000, cyc);
    check("t6_rerun_r1", dut.Reg[1], 32'd0);
    check("t6_rerun_r2", dut.Reg[2], 32'd100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
